// File: rtl/riscv_wb_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
// The address/data widths here are the defaults used by riscv_regfile_wb_arbiter.
package riscv_wb_pkg;

    localparam int WB_ADDR_WIDTH = 6;
    localparam int WB_DATA_WIDTH = 32;

    localparam logic [WB_ADDR_WIDTH-1:0] REG_X0 = '0;

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_req_t;

    // Top address bit selects the FP bank; a disabled FP file folds it onto the integer bank.
    function automatic logic [WB_ADDR_WIDTH-1:0] eff_addr(
        input logic [WB_ADDR_WIDTH-1:0] addr,
        input logic                     fregfile_disable
    );
        return {addr[WB_ADDR_WIDTH-1] & ~fregfile_disable, addr[WB_ADDR_WIDTH-2:0]};
    endfunction

endpackage

// File: rtl/riscv_wb_fifo.sv
// Generic synchronous FIFO with an occupancy counter and a registered full flag.
// Push into a full FIFO and pop from an empty FIFO are ignored.
module riscv_wb_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    logic             push_ok;
    logic             pop_ok;

    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + (PTR_W+1)'(1);
        end else if (!push_ok && pop_ok) begin
            count_next = count - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            full  <= (count_next == (PTR_W+1)'(DEPTH));
        end
    end

endmodule

// File: rtl/riscv_regfile_wb_arbiter.sv
// Writeback arbiter: ALU straight to W1, LSU/FPU registered onto W2 with LSU priority,
// plus a pending-write scoreboard for decode RAW stalls on long-latency destinations.
module riscv_regfile_wb_arbiter
    import riscv_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fregfile_disable_i,
    input  logic                         alu_we_i,
    input  logic [ADDR_WIDTH-1:0]        alu_waddr_i,
    input  logic [DATA_WIDTH-1:0]        alu_wdata_i,
    input  logic                         lsu_valid_i,
    input  logic [ADDR_WIDTH-1:0]        lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0]        lsu_wdata_i,
    input  logic                         fpu_valid_i,
    output logic                         fpu_ready_o,
    input  logic [ADDR_WIDTH-1:0]        fpu_waddr_i,
    input  logic [DATA_WIDTH-1:0]        fpu_wdata_i,
    input  logic                         issue_i,
    input  logic [ADDR_WIDTH-1:0]        issue_waddr_i,
    output logic [(1<<ADDR_WIDTH)-1:0]   pending_o,
    output logic [ADDR_WIDTH-1:0]        waddr_a_o,
    output logic [DATA_WIDTH-1:0]        wdata_a_o,
    output logic                         we_a_o,
    output logic [ADDR_WIDTH-1:0]        waddr_b_o,
    output logic [DATA_WIDTH-1:0]        wdata_b_o,
    output logic                         we_b_o
);

    localparam int NREGS = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] alu_addr;
    logic [ADDR_WIDTH-1:0] lsu_addr;
    logic [ADDR_WIDTH-1:0] issue_addr;
    wb_req_t               fpu_req;
    wb_req_t               fifo_head;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  fifo_pop;
    logic [NREGS-1:0]      set_vec;
    logic [NREGS-1:0]      clr_vec;

    assign alu_addr   = eff_addr(alu_waddr_i, fregfile_disable_i);
    assign lsu_addr   = eff_addr(lsu_waddr_i, fregfile_disable_i);
    assign issue_addr = eff_addr(issue_waddr_i, fregfile_disable_i);

    assign waddr_a_o = alu_addr;
    assign wdata_a_o = alu_wdata_i;
    assign we_a_o    = alu_we_i && (alu_addr != REG_X0);

    // FPU entries carry the address as masked at push time.
    assign fpu_req.addr = eff_addr(fpu_waddr_i, fregfile_disable_i);
    assign fpu_req.data = fpu_wdata_i;
    assign fpu_ready_o  = !fifo_full;
    assign fifo_pop     = !lsu_valid_i && !fifo_empty;

    riscv_wb_fifo #(
        .WIDTH ($bits(wb_req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fpu_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fpu_valid_i),
        .push_data (fpu_req),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_b_o    <= 1'b0;
            waddr_b_o <= '0;
            wdata_b_o <= '0;
        end else if (lsu_valid_i) begin
            we_b_o    <= (lsu_addr != REG_X0);
            waddr_b_o <= lsu_addr;
            wdata_b_o <= lsu_wdata_i;
        end else if (fifo_pop) begin
            we_b_o    <= (fifo_head.addr != REG_X0);
            waddr_b_o <= fifo_head.addr;
            wdata_b_o <= fifo_head.data;
        end else begin
            we_b_o <= 1'b0;
        end
    end

    // x0 is never set, so a consumed x0 write needs no explicit clear.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_i && (issue_addr != REG_X0)) set_vec[issue_addr] = 1'b1;
        if (we_b_o) clr_vec[waddr_b_o] = 1'b1;
    end

    // A new issue to a completing register must stay pending, so set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_o <= '0;
        end else begin
            pending_o <= (pending_o & ~clr_vec) | set_vec;
        end
    end

endmodule

// File: tb/tb_riscv_regfile_wb_arbiter.sv
// Directed plus randomised bench for riscv_regfile_wb_arbiter with a W2 scoreboard queue,
// an FPU FIFO reference queue and a reference pending vector.
module tb_riscv_regfile_wb_arbiter;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        fregfile_disable_i;
    logic        alu_we_i;
    logic [5:0]  alu_waddr_i;
    logic [31:0] alu_wdata_i;
    logic        lsu_valid_i;
    logic [5:0]  lsu_waddr_i;
    logic [31:0] lsu_wdata_i;
    logic        fpu_valid_i;
    logic        fpu_ready_o;
    logic [5:0]  fpu_waddr_i;
    logic [31:0] fpu_wdata_i;
    logic        issue_i;
    logic [5:0]  issue_waddr_i;
    logic [63:0] pending_o;
    logic [5:0]  waddr_a_o;
    logic [31:0] wdata_a_o;
    logic        we_a_o;
    logic [5:0]  waddr_b_o;
    logic [31:0] wdata_b_o;
    logic        we_b_o;

    riscv_regfile_wb_arbiter #(
        .ADDR_WIDTH (6),
        .DATA_WIDTH (32),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fregfile_disable_i (fregfile_disable_i),
        .alu_we_i           (alu_we_i),
        .alu_waddr_i        (alu_waddr_i),
        .alu_wdata_i        (alu_wdata_i),
        .lsu_valid_i        (lsu_valid_i),
        .lsu_waddr_i        (lsu_waddr_i),
        .lsu_wdata_i        (lsu_wdata_i),
        .fpu_valid_i        (fpu_valid_i),
        .fpu_ready_o        (fpu_ready_o),
        .fpu_waddr_i        (fpu_waddr_i),
        .fpu_wdata_i        (fpu_wdata_i),
        .issue_i            (issue_i),
        .issue_waddr_i      (issue_waddr_i),
        .pending_o          (pending_o),
        .waddr_a_o          (waddr_a_o),
        .wdata_a_o          (wdata_a_o),
        .we_a_o             (we_a_o),
        .waddr_b_o          (waddr_b_o),
        .wdata_b_o          (wdata_b_o),
        .we_b_o             (we_b_o)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard state
    logic [37:0] exp_q[$];
    logic [37:0] fq[$];
    logic [63:0] m_pending;
    int          checks;
    int          errors;
    logic        fpu_acc;

    function automatic logic [5:0] m_eff(input logic [5:0] a, input logic d);
        return {a[5] & ~d, a[4:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_we_i = 1'b0;  alu_waddr_i = '0;  alu_wdata_i = '0;
        lsu_valid_i = 1'b0; lsu_waddr_i = '0; lsu_wdata_i = '0;
        fpu_valid_i = 1'b0; fpu_waddr_i = '0; fpu_wdata_i = '0;
        issue_i = 1'b0; issue_waddr_i = '0;
    endtask

    // One clock cycle: inputs are already driven just after a falling edge.
    task automatic tick();
        logic [5:0]  ea;
        logic [37:0] e;
        logic [63:0] clr;
        logic [63:0] set;
        #1;
        ea = m_eff(alu_waddr_i, fregfile_disable_i);
        chk("we_a", 64'(we_a_o), 64'(alu_we_i && ea != 6'd0));
        if (alu_we_i && ea != 6'd0) chk("w1_addr_data", {26'd0, waddr_a_o, wdata_a_o}, {26'd0, ea, alu_wdata_i});
        chk("fpu_ready", 64'(fpu_ready_o), 64'(fq.size() < DEPTH));
        chk("pending", pending_o, m_pending);
        clr = '0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("we_b", 64'(we_b_o), 64'd1);
            chk("w2_addr_data", {26'd0, waddr_b_o, wdata_b_o}, {26'd0, e});
            clr[e[37:32]] = 1'b1;
        end else begin
            chk("we_b_idle", 64'(we_b_o), 64'd0);
        end
        set = '0;
        ea = m_eff(issue_waddr_i, fregfile_disable_i);
        if (issue_i && ea != 6'd0) set[ea] = 1'b1;
        m_pending = (m_pending & ~clr) | set;
        fpu_acc = fpu_valid_i && (fq.size() < DEPTH);
        if (lsu_valid_i) begin
            ea = m_eff(lsu_waddr_i, fregfile_disable_i);
            if (ea != 6'd0) exp_q.push_back({ea, lsu_wdata_i});
        end else if (fq.size() > 0) begin
            e = fq.pop_front();
            if (e[37:32] != 6'd0) exp_q.push_back(e);
        end
        if (fpu_acc) fq.push_back({m_eff(fpu_waddr_i, fregfile_disable_i), fpu_wdata_i});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        idle_inputs();
        for (int i = 0; i < 30; i++) begin
            if (fq.size() == 0 && exp_q.size() == 0) break;
            tick();
        end
        tick();
        chk("drain_empty", 64'(fq.size() + exp_q.size()), 64'd0);
    endtask

    initial begin
        int fpu_idx;
        int acc_lsu;
        checks = 0;
        errors = 0;
        m_pending = '0;
        fpu_acc = 1'b0;
        fregfile_disable_i = 1'b0;
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_pending", pending_o, 64'd0);
        chk("rst_we_b", 64'(we_b_o), 64'd0);
        chk("rst_w2", {26'd0, waddr_b_o, wdata_b_o}, 64'd0);
        chk("rst_ready", 64'(fpu_ready_o), 64'd1);
        chk("rst_we_a", 64'(we_a_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ALU to x5 then x0
        alu_we_i = 1'b1; alu_waddr_i = 6'd5; alu_wdata_i = 32'h1234;
        tick();
        alu_waddr_i = 6'd0; alu_wdata_i = 32'hFFFF;
        tick();
        idle_inputs();

        // Issue x10, load returns three cycles later
        issue_i = 1'b1; issue_waddr_i = 6'd10;
        tick();
        idle_inputs();
        tick();
        tick();
        chk("pend10_before", 64'(pending_o[10]), 64'd1);
        lsu_valid_i = 1'b1; lsu_waddr_i = 6'd10; lsu_wdata_i = 32'hAA;
        tick();
        idle_inputs();
        tick();
        chk("pend10_after", 64'(pending_o[10]), 64'd0);

        // LSU burst of 6 while the FPU offers 5 results
        for (int i = 0; i < 5; i++) begin
            issue_i = 1'b1; issue_waddr_i = 6'(33 + i);
            tick();
        end
        fpu_idx = 0;
        acc_lsu = 0;
        for (int c = 0; c < 6; c++) begin
            issue_i = 1'b0;
            lsu_valid_i = 1'b1; lsu_waddr_i = 6'(c + 1); lsu_wdata_i = 32'h100 + 32'(c);
            fpu_valid_i = (fpu_idx < 5);
            fpu_waddr_i = 6'(33 + fpu_idx); fpu_wdata_i = 32'hF00 + 32'(fpu_idx);
            tick();
            if (fpu_acc) begin
                fpu_idx++;
                acc_lsu++;
            end
        end
        chk("burst_accepted", 64'(acc_lsu), 64'd4);
        lsu_valid_i = 1'b0;
        for (int c = 0; c < 20 && fpu_idx < 5; c++) begin
            fpu_valid_i = 1'b1;
            fpu_waddr_i = 6'(33 + fpu_idx); fpu_wdata_i = 32'hF00 + 32'(fpu_idx);
            tick();
            if (fpu_acc) fpu_idx++;
        end
        chk("burst_all_pushed", 64'(fpu_idx), 64'd5);
        drain();
        chk("burst_pending_clear", pending_o & 64'h0000_003E_0000_007E, 64'd0);

        // FP file disabled: address 33 folds onto x1, masking latched at push
        fregfile_disable_i = 1'b1;
        issue_i = 1'b1; issue_waddr_i = 6'd33;
        tick();
        idle_inputs();
        fpu_valid_i = 1'b1; fpu_waddr_i = 6'd33; fpu_wdata_i = 32'h55;
        tick();
        idle_inputs();
        fregfile_disable_i = 1'b0;
        drain();
        chk("dis_pend1", 64'(pending_o[1]), 64'd0);
        issue_i = 1'b1; issue_waddr_i = 6'd33;
        tick();
        idle_inputs();
        chk("en_pend33_set", 64'(pending_o[33]), 64'd1);
        fpu_valid_i = 1'b1; fpu_waddr_i = 6'd33; fpu_wdata_i = 32'h66;
        tick();
        idle_inputs();
        drain();
        chk("en_pend33_clr", 64'(pending_o[33]), 64'd0);

        // f3 completes on W2 in the same cycle it is re-issued
        issue_i = 1'b1; issue_waddr_i = 6'd35;
        tick();
        idle_inputs();
        fpu_valid_i = 1'b1; fpu_waddr_i = 6'd35; fpu_wdata_i = 32'h3333;
        tick();
        idle_inputs();
        tick();
        chk("f3_w2_now", {57'd0, we_b_o, waddr_b_o}, {57'd0, 1'b1, 6'd35});
        issue_i = 1'b1; issue_waddr_i = 6'd35;
        tick();
        idle_inputs();
        tick();
        chk("f3_set_wins", 64'(pending_o[35]), 64'd1);

        // Collision: W1 and W2 to the same register in one cycle
        lsu_valid_i = 1'b1; lsu_waddr_i = 6'd7; lsu_wdata_i = 32'h77;
        tick();
        idle_inputs();
        alu_we_i = 1'b1; alu_waddr_i = 6'd7; alu_wdata_i = 32'h78;
        tick();
        idle_inputs();

        // Reset mid-operation with 3 FIFO entries and 4 new pending bits
        m_pending = pending_o;
        for (int c = 0; c < 4; c++) begin
            lsu_valid_i = 1'b1; lsu_waddr_i = 6'(20 + c); lsu_wdata_i = 32'h200 + 32'(c);
            issue_i = 1'b1; issue_waddr_i = 6'(40 + c);
            fpu_valid_i = (c < 3); fpu_waddr_i = 6'(50 + c); fpu_wdata_i = 32'h500 + 32'(c);
            tick();
        end
        idle_inputs();
        chk("pre_rst_pending", 64'($countones(pending_o & 64'h0000_0F00_0000_0000)), 64'd4);
        chk("pre_rst_fifo", 64'(fq.size()), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pending", pending_o, 64'd0);
        chk("mid_rst_we_b", 64'(we_b_o), 64'd0);
        chk("mid_rst_ready", 64'(fpu_ready_o), 64'd1);
        fq.delete();
        exp_q.delete();
        m_pending = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) tick();

        // Randomised traffic; FPU holds its payload while not accepted
        fpu_acc = 1'b0;
        for (int c = 0; c < 300; c++) begin
            alu_we_i = 1'($urandom_range(0, 1));
            alu_waddr_i = 6'($urandom_range(0, 63));
            alu_wdata_i = $urandom;
            lsu_valid_i = ($urandom_range(0, 2) == 0);
            lsu_waddr_i = 6'($urandom_range(0, 63));
            lsu_wdata_i = $urandom;
            issue_i = 1'($urandom_range(0, 1));
            issue_waddr_i = 6'($urandom_range(0, 63));
            fregfile_disable_i = ($urandom_range(0, 7) == 0);
            if (!fpu_valid_i || fpu_acc) begin
                fpu_valid_i = 1'($urandom_range(0, 1));
                fpu_waddr_i = 6'($urandom_range(0, 63));
                fpu_wdata_i = $urandom;
            end
            tick();
        end
        fregfile_disable_i = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
